ratio_phase_ctrl: RTL and testbench
===================================

Name: ratio_phase_ctrl

Overview:
Fast-domain controller that generates the clk_cnt phase index for the fast2slow and slow2fast channel-bounding buffers. It locks that index to the slow clock. Lock is derived from a slow-domain toggle flop, which is synchronised and edge-detected in clk. Until lock is achieved and held, the controller holds the buffers in reset. It also reports lock status and phase-miss statistics to the RIFL status logic.

Parameters:
RATIO, 2, fast/slow clock frequency ratio; integer, must be >= 2; clk_cnt width CW = $clog2(RATIO)
SYNC_STAGES, 2, synchroniser depth for slow_toggle; must be >= 2
ALIGN_CNT, 0, clk_cnt value that must be current on a clk edge where a toggle edge is detected; must be < RATIO
LOCK_EDGES, 4, consecutive matching edges required in VERIFY to declare lock; must be >= 1
UNLOCK_MISSES, 2, consecutive mismatching edges in LOCKED that force relock; must be >= 1

Ports:
clk  in  1  fast clock
rst  in  1  synchronous, active-high reset
slow_toggle  in  1  asynchronous; inverts on every slow-clock rising edge
clk_cnt  out  CW  phase index, drives buffer clk_cnt inputs
sample_edge  out  1  combinational, high when clk_cnt == RATIO-1
locked  out  1  high in LOCKED state
buf_rst  out  1  high whenever state != LOCKED; drives buffer rst
unlock_pulse  out  1  one-cycle pulse on any LOCKED -> SEARCH transition
miss_cnt  out  8  total phase misses seen in LOCKED; saturates at 255; cleared only by rst

Behaviour:
- Reset values: clk_cnt=0, state=SEARCH, locked=0, buf_rst=1, unlock_pulse=0, miss_cnt=0, synchroniser flops=0, edge-detect history=0, good=0, miss_run=0, wd=0.
- Edge detect:
  - tog_edge = last synchroniser stage XOR its previous registered value.
  - An input toggle is therefore seen SYNC_STAGES+1 clk edges later, give or take one cycle of metastability.
- Counter:
  - Default each cycle: clk_cnt <= (clk_cnt == RATIO-1) ? 0 : clk_cnt+1.
  - "Realign" means clk_cnt <= (ALIGN_CNT+1) mod RATIO on that edge.
  - After a realign, an edge arriving RATIO cycles later finds clk_cnt == ALIGN_CNT.
- Watchdog:
  - wd clears on every tog_edge; otherwise it increments.
  - In VERIFY or LOCKED, if wd reaches RATIO+2 with no edge, the state goes to SEARCH. Same cycle: wd cleared, counters cleared.
  - In SEARCH the watchdog is ignored.
- SEARCH:
  - clk_cnt free-runs.
  - On tog_edge: realign, good=0, go to VERIFY.
- VERIFY:
  - On tog_edge with clk_cnt == ALIGN_CNT: good++, counter free-runs.
  - If good+1 == LOCK_EDGES: go to LOCKED and set miss_run=0. locked and buf_rst change on that same clk edge.
  - On tog_edge with a mismatch: realign, good=0, stay in VERIFY.
- LOCKED:
  - Matching edge: miss_run=0.
  - Mismatching edge:
    - miss_run++, and miss_cnt++ (saturating).
    - No realign; the counter keeps free-running.
    - If miss_run+1 == UNLOCK_MISSES: go to SEARCH, assert unlock_pulse for one cycle, buf_rst=1, good=0, miss_run=0.
- Simultaneous events: a tog_edge in the same cycle wd would reach RATIO+2 counts as an edge; the watchdog does not fire.
- rst asserted in any state: all reset values on the next clk edge. There is no partial state retention.
- buf_rst and locked are registered and are exact complements in all cycles after reset.
- sample_edge is the only combinational output.

Decomposition:
- Package rifl_phase_pkg holds:
  - enum phase_state_t {SEARCH, VERIFY, LOCKED} (2 bits);
  - localparam function wd_limit(ratio) = ratio+2.
- Sub-module toggle_sync: SYNC_STAGES flop chain plus edge-detect flop. Outputs tog_edge; reset to 0.
- All FSM and counter logic lives in ratio_phase_ctrl.

Test Plan:
1. RATIO=2, ALIGN_CNT=0, slow_toggle inverts every 2 clk -> locked rises on the 5th detected edge (1 SEARCH edge plus 4 VERIFY edges) with buf_rst falling the same cycle. In lock, every tog_edge coincides with clk_cnt==0 and miss_cnt stays 0.
2. Locked, RATIO=2, toggle stops -> 4 cycles after the last edge: state SEARCH, locked=0, buf_rst=1, unlock_pulse high exactly 1 cycle, miss_cnt unchanged.
3. Locked, a single toggle delayed 1 clk, then back on grid -> miss_cnt=1, locked stays 1. Two consecutive delayed toggles -> miss_cnt=3 total and unlock on the second miss.
4. VERIFY after 2 good edges, one edge off-phase -> realign (clk_cnt=1 on the next cycle), good=0. Lock then needs 4 further matching edges.
5. rst pulsed for 1 cycle while LOCKED -> next cycle clk_cnt=0, locked=0, buf_rst=1, miss_cnt=0, unlock_pulse=0. Relock then follows scenario 1 timing.
6. RATIO=3, ALIGN_CNT=2, toggle every 3 clk -> clk_cnt sequence 0,1,2 with sample_edge high only at 2. Lock after 5 edges with every in-lock edge at clk_cnt==2; miss_cnt stays 0.

Source files
------------

// File: rtl/rifl_phase_pkg.sv
// Shared types and helpers for the fast-domain phase controller.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package rifl_phase_pkg;

  // Controller states: hunting for a slow edge, confirming phase, holding lock.
  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } phase_state_t;

  // Longest gap, in fast cycles, tolerated between slow edges before lock is dropped.
  function automatic int wd_limit(input int ratio);
    return ratio + 2;
  endfunction

endpackage

// File: rtl/ratio_phase_ctrl_if.sv
// Bundle between the phase controller and the buffers and status logic it serves.
// Latency: n/a (wires only).
// Backpressure: none; every signal is a level or a single-cycle pulse.
interface ratio_phase_ctrl_if #(
  parameter int RATIO = 2
);
  localparam int CW = $clog2(RATIO);

  logic          slow_toggle;
  logic [CW-1:0] clk_cnt;
  logic          sample_edge;
  logic          locked;
  logic          buf_rst;
  logic          unlock_pulse;
  logic [7:0]    miss_cnt;

  // Controller side: consumes the slow toggle, produces phase and status.
  modport master (
    input  slow_toggle,
    output clk_cnt, sample_edge, locked, buf_rst, unlock_pulse, miss_cnt
  );

  // Buffer and status side: supplies the slow toggle, consumes phase and status.
  modport slave (
    output slow_toggle,
    input  clk_cnt, sample_edge, locked, buf_rst, unlock_pulse, miss_cnt
  );
endinterface

// File: rtl/ratio_phase_ctrl_toggle_sync.sv
// Synchronises the slow-domain toggle into clk and flags each change of level.
// Latency: a level change shows up on tog_edge SYNC_STAGES clk edges later (+/-1 for metastability).
// Backpressure: none; free-running.
module toggle_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic slow_toggle,
  output logic tog_edge
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // Shift the asynchronous toggle through the chain and remember the last settled level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], slow_toggle};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign tog_edge = sync_q[SYNC_STAGES-1] ^ hist_q;

endmodule

// File: rtl/ratio_phase_ctrl.sv
// Locks the fast-domain clk_cnt phase index to the slow clock and gates buffer reset on lock.
// Latency: slow edge acts SYNC_STAGES+1 clk edges after the toggle; all outputs but sample_edge registered.
// Backpressure: none; free-running controller with no flow control.
module ratio_phase_ctrl
  import rifl_phase_pkg::*;
#(
  parameter int RATIO         = 2,
  parameter int SYNC_STAGES   = 2,
  parameter int ALIGN_CNT     = 0,
  parameter int LOCK_EDGES    = 4,
  parameter int UNLOCK_MISSES = 2
) (
  input  logic               clk,
  input  logic               rst,
  ratio_phase_ctrl_if.master bus
);

  localparam int CW       = $clog2(RATIO);
  localparam int GW       = $clog2(LOCK_EDGES + 1);
  localparam int MW       = $clog2(UNLOCK_MISSES + 1);
  localparam int WD_LIMIT = wd_limit(RATIO);
  localparam int WW       = $clog2(WD_LIMIT + 1);

  localparam logic [CW-1:0] CNT_MAX   = CW'(RATIO - 1);
  localparam logic [CW-1:0] ALIGN_VAL = CW'(ALIGN_CNT);
  // Loading ALIGN_CNT+1 makes the next on-grid edge, RATIO cycles away, land on ALIGN_CNT.
  localparam logic [CW-1:0] REALIGN   = CW'((ALIGN_CNT + 1) % RATIO);
  localparam logic [WW-1:0] WD_FIRE   = WW'(WD_LIMIT - 1);
  localparam logic [WW-1:0] WD_SAT    = WW'(WD_LIMIT);

  phase_state_t  state_q;
  logic [CW-1:0] clk_cnt_q;
  logic [GW-1:0] good_q;
  logic [MW-1:0] miss_run_q;
  logic [WW-1:0] wd_q;
  logic [7:0]    miss_cnt_q;
  logic          locked_q;
  logic          buf_rst_q;
  logic          unlock_pulse_q;

  logic          tog_edge;
  logic          phase_ok;
  logic          wd_fire;
  logic [CW-1:0] cnt_next;

  toggle_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_toggle_sync (
    .clk         (clk),
    .rst         (rst),
    .slow_toggle (bus.slow_toggle),
    .tog_edge    (tog_edge)
  );

  assign phase_ok = (clk_cnt_q == ALIGN_VAL);
  // An edge arriving in the same cycle always beats the watchdog.
  assign wd_fire  = !tog_edge && (wd_q == WD_FIRE);
  assign cnt_next = (clk_cnt_q == CNT_MAX) ? '0 : clk_cnt_q + CW'(1);

  // Phase counter, watchdog and lock FSM; every status output is registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= SEARCH;
      clk_cnt_q      <= '0;
      good_q         <= '0;
      miss_run_q     <= '0;
      wd_q           <= '0;
      miss_cnt_q     <= '0;
      locked_q       <= 1'b0;
      buf_rst_q      <= 1'b1;
      unlock_pulse_q <= 1'b0;
    end else begin
      unlock_pulse_q <= 1'b0;
      clk_cnt_q      <= cnt_next;

      // Watchdog counts cycles since the last slow edge; saturates so SEARCH can idle forever.
      if (tog_edge) begin
        wd_q <= '0;
      end else if (wd_q != WD_SAT) begin
        wd_q <= wd_q + WW'(1);
      end

      case (state_q)
        SEARCH: begin
          if (tog_edge) begin
            clk_cnt_q <= REALIGN;
            good_q    <= '0;
            state_q   <= VERIFY;
          end
        end

        VERIFY: begin
          if (tog_edge) begin
            if (phase_ok) begin
              if (good_q + GW'(1) == GW'(LOCK_EDGES)) begin
                state_q    <= LOCKED;
                miss_run_q <= '0;
                locked_q   <= 1'b1;
                buf_rst_q  <= 1'b0;
              end else begin
                good_q <= good_q + GW'(1);
              end
            end else begin
              clk_cnt_q <= REALIGN;
              good_q    <= '0;
            end
          end else if (wd_fire) begin
            state_q    <= SEARCH;
            wd_q       <= '0;
            good_q     <= '0;
            miss_run_q <= '0;
          end
        end

        LOCKED: begin
          if (tog_edge) begin
            if (phase_ok) begin
              miss_run_q <= '0;
            end else begin
              // Misses are counted but never realign: a locked channel keeps its phase.
              if (miss_cnt_q != 8'hFF) begin
                miss_cnt_q <= miss_cnt_q + 8'd1;
              end
              if (miss_run_q + MW'(1) == MW'(UNLOCK_MISSES)) begin
                state_q        <= SEARCH;
                unlock_pulse_q <= 1'b1;
                locked_q       <= 1'b0;
                buf_rst_q      <= 1'b1;
                good_q         <= '0;
                miss_run_q     <= '0;
              end else begin
                miss_run_q <= miss_run_q + MW'(1);
              end
            end
          end else if (wd_fire) begin
            state_q        <= SEARCH;
            unlock_pulse_q <= 1'b1;
            locked_q       <= 1'b0;
            buf_rst_q      <= 1'b1;
            wd_q           <= '0;
            good_q         <= '0;
            miss_run_q     <= '0;
          end
        end

        default: begin
          state_q    <= SEARCH;
          locked_q   <= 1'b0;
          buf_rst_q  <= 1'b1;
          good_q     <= '0;
          miss_run_q <= '0;
        end
      endcase
    end
  end

  assign bus.clk_cnt      = clk_cnt_q;
  assign bus.sample_edge  = (clk_cnt_q == CNT_MAX);
  assign bus.locked       = locked_q;
  assign bus.buf_rst      = buf_rst_q;
  assign bus.unlock_pulse = unlock_pulse_q;
  assign bus.miss_cnt     = miss_cnt_q;

endmodule

// File: tb/tb_ratio_phase_ctrl.sv
// Directed bench: two controllers (RATIO=2/ALIGN=0 and RATIO=3/ALIGN=2) driven by scheduled toggles.
// Latency: expected cycle numbers are hand-derived from toggle edge + SYNC_STAGES+1.
// Backpressure: n/a.
module tb_ratio_phase_ctrl;

  logic clk;
  logic rst_a;
  logic rst_b;

  int checks;
  int errors;
  int cyc;
  int period;
  int ofs;
  bit tog_en;
  bit sel;

  ratio_phase_ctrl_if #(.RATIO(2)) bus_a ();
  ratio_phase_ctrl_if #(.RATIO(3)) bus_b ();

  ratio_phase_ctrl #(
    .RATIO(2), .SYNC_STAGES(2), .ALIGN_CNT(0), .LOCK_EDGES(4), .UNLOCK_MISSES(2)
  ) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  ratio_phase_ctrl #(
    .RATIO(3), .SYNC_STAGES(2), .ALIGN_CNT(2), .LOCK_EDGES(4), .UNLOCK_MISSES(2)
  ) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic flip();
    if (sel) bus_b.slow_toggle = ~bus_b.slow_toggle;
    else     bus_a.slow_toggle = ~bus_a.slow_toggle;
  endtask

  // Advance n cycles; toggle on the grid cyc % period == ofs, sample 1ns after each edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      if (tog_en && (cyc % period == ofs)) flip();
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    period = 2;
    ofs    = 0;
    tog_en = 1'b0;
    sel    = 1'b0;
    rst_a  = 1'b1;
    rst_b  = 1'b1;
    bus_a.slow_toggle = 1'b0;
    bus_b.slow_toggle = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_clk_cnt",  32'(bus_a.clk_cnt),      0);
    chk("rst_a_locked",   32'(bus_a.locked),       0);
    chk("rst_a_buf_rst",  32'(bus_a.buf_rst),      1);
    chk("rst_a_unlock",   32'(bus_a.unlock_pulse), 0);
    chk("rst_a_miss",     32'(bus_a.miss_cnt),     0);
    chk("rst_a_sample",   32'(bus_a.sample_edge),  0);
    chk("rst_b_clk_cnt",  32'(bus_b.clk_cnt),      0);
    chk("rst_b_buf_rst",  32'(bus_b.buf_rst),      1);

    // Scenario 1: toggles every 2 clk from edge 0; detections at edges 3,5,7,9,11.
    rst_a  = 1'b0;
    tog_en = 1'b1;
    step(3);
    chk("s1_realign_cnt", 32'(bus_a.clk_cnt), 1);
    chk("s1_e3_locked",   32'(bus_a.locked),  0);
    step(7);
    chk("s1_e10_locked",  32'(bus_a.locked),  0);
    chk("s1_e10_buf_rst", 32'(bus_a.buf_rst), 1);
    step(1);
    chk("s1_e11_locked",  32'(bus_a.locked),  1);
    chk("s1_e11_buf_rst", 32'(bus_a.buf_rst), 0);
    chk("s1_e11_unlock",  32'(bus_a.unlock_pulse), 0);
    step(1);
    chk("s1_e12_cnt",     32'(bus_a.clk_cnt),     0);
    chk("s1_e12_sample",  32'(bus_a.sample_edge), 0);
    step(1);
    chk("s1_e13_cnt",     32'(bus_a.clk_cnt),     1);
    chk("s1_e13_sample",  32'(bus_a.sample_edge), 1);
    chk("s1_e13_miss",    32'(bus_a.miss_cnt),    0);

    // Scenario 3a: toggle due at 16 moved to 17 -> one miss at edge 20, lock kept.
    step(3);
    tog_en = 1'b0;
    step(1);
    flip();
    tog_en = 1'b1;
    step(3);
    chk("s3_e20_miss",    32'(bus_a.miss_cnt), 1);
    chk("s3_e20_locked",  32'(bus_a.locked),   1);
    step(1);
    chk("s3_e21_miss",    32'(bus_a.miss_cnt), 1);
    chk("s3_e21_locked",  32'(bus_a.locked),   1);

    // Scenario 3b: toggles at 27 and 29 -> misses at 30 and 32, unlock at 32.
    step(5);
    tog_en = 1'b0;
    step(1);
    flip();
    step(2);
    flip();
    tog_en = 1'b1;
    step(1);
    chk("s3_e30_miss",    32'(bus_a.miss_cnt), 2);
    chk("s3_e30_locked",  32'(bus_a.locked),   1);
    step(2);
    chk("s3_e32_miss",    32'(bus_a.miss_cnt),     3);
    chk("s3_e32_locked",  32'(bus_a.locked),       0);
    chk("s3_e32_buf_rst", 32'(bus_a.buf_rst),      1);
    chk("s3_e32_unlock",  32'(bus_a.unlock_pulse), 1);
    step(1);
    chk("s3_e33_unlock",  32'(bus_a.unlock_pulse), 0);
    step(8);
    chk("s3_e41_relock",  32'(bus_a.locked), 1);

    // Scenario 2: toggling stops after edge 40; last detection 43, watchdog drops lock at 47.
    tog_en = 1'b0;
    step(5);
    chk("s2_e46_locked",  32'(bus_a.locked), 1);
    step(1);
    chk("s2_e47_locked",  32'(bus_a.locked),       0);
    chk("s2_e47_buf_rst", 32'(bus_a.buf_rst),      1);
    chk("s2_e47_unlock",  32'(bus_a.unlock_pulse), 1);
    chk("s2_e47_miss",    32'(bus_a.miss_cnt),     3);
    step(1);
    chk("s2_e48_unlock",  32'(bus_a.unlock_pulse), 0);

    // Scenario 4: two good VERIFY edges (53,55), then off-phase edge at 58 realigns.
    tog_en = 1'b1;
    step(6);
    tog_en = 1'b0;
    step(1);
    ofs    = 1;
    tog_en = 1'b1;
    step(3);
    chk("s4_e58_realign", 32'(bus_a.clk_cnt), 1);
    chk("s4_e58_locked",  32'(bus_a.locked),  0);
    step(6);
    chk("s4_e64_locked",  32'(bus_a.locked),  0);
    step(2);
    chk("s4_e66_locked",  32'(bus_a.locked),  1);
    chk("s4_e66_buf_rst", 32'(bus_a.buf_rst), 0);

    // Scenario 5: one-cycle reset while locked, then relock on the scenario 1 schedule.
    rst_a  = 1'b1;
    tog_en = 1'b0;
    bus_a.slow_toggle = 1'b0;
    step(1);
    chk("s5_rst_cnt",     32'(bus_a.clk_cnt),      0);
    chk("s5_rst_locked",  32'(bus_a.locked),       0);
    chk("s5_rst_buf_rst", 32'(bus_a.buf_rst),      1);
    chk("s5_rst_miss",    32'(bus_a.miss_cnt),     0);
    chk("s5_rst_unlock",  32'(bus_a.unlock_pulse), 0);
    rst_a  = 1'b0;
    cyc    = 0;
    ofs    = 0;
    tog_en = 1'b1;
    step(10);
    chk("s5_e10_locked",  32'(bus_a.locked), 0);
    step(1);
    chk("s5_e11_locked",  32'(bus_a.locked),  1);
    chk("s5_e11_buf_rst", 32'(bus_a.buf_rst), 0);

    // Scenario 6: RATIO=3, ALIGN_CNT=2, toggles every 3 clk; detections at 3,6,9,12,15,18.
    rst_a  = 1'b1;
    tog_en = 1'b0;
    sel    = 1'b1;
    cyc    = 0;
    period = 3;
    ofs    = 0;
    rst_b  = 1'b0;
    tog_en = 1'b1;
    step(1);
    chk("s6_e1_cnt",      32'(bus_b.clk_cnt),     1);
    chk("s6_e1_sample",   32'(bus_b.sample_edge), 0);
    step(1);
    chk("s6_e2_cnt",      32'(bus_b.clk_cnt),     2);
    chk("s6_e2_sample",   32'(bus_b.sample_edge), 1);
    step(1);
    chk("s6_e3_cnt",      32'(bus_b.clk_cnt),     0);
    step(9);
    chk("s6_e12_locked",  32'(bus_b.locked), 0);
    step(3);
    chk("s6_e15_locked",  32'(bus_b.locked),  1);
    chk("s6_e15_buf_rst", 32'(bus_b.buf_rst), 0);
    step(1);
    chk("s6_e16_cnt",     32'(bus_b.clk_cnt), 1);
    step(1);
    chk("s6_e17_cnt",     32'(bus_b.clk_cnt),     2);
    chk("s6_e17_sample",  32'(bus_b.sample_edge), 1);
    step(1);
    chk("s6_e18_cnt",     32'(bus_b.clk_cnt),     0);
    chk("s6_e18_sample",  32'(bus_b.sample_edge), 0);
    chk("s6_e18_miss",    32'(bus_b.miss_cnt),    0);
    chk("s6_e18_locked",  32'(bus_b.locked),      1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
